fx1_issue_ctrl: RTL and testbench
=================================

Name: fx1_issue_ctrl

Overview:
- Sequencing and pipeline controller for the FX1 fixed-point ALU in the SPU even pipe.
- Accepts one issued FX1 instruction per cycle and drives the combinational FX1 ALU.
- Carries the result through LATENCY register stages and presents it to the register-file writeback port with a valid/ready handshake.
- Also supplies per-stage forwarding data, stall back-pressure, flush handling and illegal-opcode detection.

Parameters:
- LATENCY, 2, number of result register stages from issue to writeback (legal range 1..4).
- DATA_W, 128, operand/result width.
- ADDR_W, 7, register-file address width.
- ID_W, 7, instruction-ID width, matching the opcode package encoding.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue slot holds an FX1 instruction.
- issue_ready  out  1  controller accepts the instruction this cycle.
- issue_instr_id  in  ID_W  instruction ID from the opcode package.
- issue_rt_addr  in  ADDR_W  destination register.
- issue_ra, issue_rb, issue_rc  in  DATA_W each  operand data; rc also carries rt data for addx/bgx/cgx/sfx/iohl.
- issue_imme7 / imme10 / imme16 / imme18  in  8/10/16/18  immediate fields.
- alu_instr_id  out  ID_W  to ALU.
- alu_ra, alu_rb, alu_rc  out  DATA_W  to ALU.
- alu_imme7 / 10 / 16 / 18  out  to ALU.
- alu_result  in  DATA_W  combinational ALU result.
- flush  in  1  kill all in-flight FX1 instructions (branch mispredict/exception).
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  register-file write port accepts.
- wb_rt_addr  out  ADDR_W  writeback address.
- wb_data  out  DATA_W  writeback data.
- fwd_valid  out  LATENCY  per-stage valid; bit 0 = stage 1.
- fwd_rt_addr  out  LATENCY*ADDR_W  per-stage destination, stage 1 in the MS slice.
- fwd_data  out  LATENCY*DATA_W  per-stage result, same ordering.
- occupancy  out  3  count of valid stages, 0..LATENCY.
- err_illegal  out  1  registered one-cycle pulse.

Behaviour:
- Reset state: all stage valid bits, addresses and data = 0. wb_valid = 0, err_illegal = 0, occupancy = 0. issue_ready = 1 after reset.
- ALU drive: alu_* outputs are combinational pass-throughs of the issue_* inputs. alu_result is sampled on the acceptance edge; no ALU state is held.
- Advance condition: advance = ~(stage_v[LATENCY] & ~wb_ready). This is a global stall: all stages hold when the last stage is valid and not accepted.
- issue_ready = advance & ~flush.
- Acceptance:
  - When issue_valid & issue_ready and the ID is in the FX1 set (41 IDs, a..xori), stage 1 loads {1, issue_rt_addr, alu_result} and stage k loads stage k-1.
  - When advance is high with no acceptance, a bubble (valid = 0) enters stage 1.
- Illegal ID: issue_valid & issue_ready with a non-FX1 ID → instruction consumed, bubble inserted, err_illegal = 1 the next cycle only.
- Writeback:
  - wb_valid = stage_v[LATENCY] & ~flush.
  - wb_rt_addr / wb_data = last-stage registers.
  - A transfer occurs when wb_valid & wb_ready.
  - wb_* stay stable while stalled.
- Latency: a result accepted at edge N appears on wb_* in the cycle after edge N+LATENCY-1 (LATENCY=2: visible 2 cycles after the issue cycle), absent stalls.
- Throughput: 1 per cycle with wb_ready held high.
- Flush:
  - Synchronous; overrides stall and issue.
  - At the edge, all stage_v clear; nothing is accepted that cycle; no writeback transfer occurs in the flush cycle.
  - Data registers are not required to clear.
- Forwarding: fwd_valid[k] = stage_v[k+1] & ~flush, with matching addr/data. Valid during stalls.
- occupancy: registered popcount of stage_v, updated every edge.
- Reset mid-operation: in-flight work is discarded with no writeback. A reset asserted together with flush or issue_valid has priority.
- Simultaneous stall + issue_valid: issue_ready = 0; the issuer holds its inputs.

Test Plan:
- reset then issue `a` with ra words = 0x00000001, rb words = 0x00000002, rt = 5, wb_ready = 1 → wb_valid = 1 with wb_rt_addr = 5 and all four words 0x00000003 exactly 2 cycles after issue; occupancy 1→1→0.
- Back-to-back issue of il imme16 = 0x0007 (rt 1), ila imme18 = 0x3FFFF (rt 2), ai ra = 0x10 imme10 = 0x3FF (rt 3) → wb on three consecutive cycles: words 0x00000007, 0x0003FFFF, 0x0000000F; fwd_valid = 2'b11 mid-stream.
- Pipeline full, wb_ready = 0 for 3 cycles → issue_ready = 0 and wb_data held constant for 3 cycles; on release, drains in order with no loss or duplication.
- flush asserted with 2 in flight plus a concurrent issue → next cycle wb_valid = 0, fwd_valid = 0, occupancy = 0; no writeback of any of the 3.
- issue_valid with an unassigned instr_id → err_illegal = 1 for exactly one cycle; no wb_valid two cycles later.
- reset asserted while 2 in flight and wb_ready = 0 → next cycle all outputs at reset values; issue_ready = 1.

Source files
------------

// File: rtl/fx1_issue_ctrl.sv
// FX1 fixed-point issue/pipeline controller: drives the combinational FX1 ALU,
// stages results LATENCY deep with forwarding, and hands them to writeback.
module fx1_issue_ctrl #(
  parameter int LATENCY = 2,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 7,
  parameter int ID_W    = 7
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [ID_W-1:0]             issue_instr_id,
  input  logic [ADDR_W-1:0]           issue_rt_addr,
  input  logic [DATA_W-1:0]           issue_ra,
  input  logic [DATA_W-1:0]           issue_rb,
  input  logic [DATA_W-1:0]           issue_rc,
  input  logic [7:0]                  issue_imme7,
  input  logic [9:0]                  issue_imme10,
  input  logic [15:0]                 issue_imme16,
  input  logic [17:0]                 issue_imme18,
  output logic [ID_W-1:0]             alu_instr_id,
  output logic [DATA_W-1:0]           alu_ra,
  output logic [DATA_W-1:0]           alu_rb,
  output logic [DATA_W-1:0]           alu_rc,
  output logic [7:0]                  alu_imme7,
  output logic [9:0]                  alu_imme10,
  output logic [15:0]                 alu_imme16,
  output logic [17:0]                 alu_imme18,
  input  logic [DATA_W-1:0]           alu_result,
  input  logic                        flush,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [ADDR_W-1:0]           wb_rt_addr,
  output logic [DATA_W-1:0]           wb_data,
  output logic [LATENCY-1:0]          fwd_valid,
  output logic [LATENCY*ADDR_W-1:0]   fwd_rt_addr,
  output logic [LATENCY*DATA_W-1:0]   fwd_data,
  output logic [2:0]                  occupancy,
  output logic                        err_illegal
);

  // FX1 instructions (a .. xori, 41 IDs) occupy one contiguous block of the opcode encoding.
  localparam logic [ID_W-1:0] FX1_ID_FIRST = ID_W'(1);
  localparam logic [ID_W-1:0] FX1_ID_LAST  = ID_W'(41);

  function automatic logic is_fx1(input logic [ID_W-1:0] id);
    return (id >= FX1_ID_FIRST) && (id <= FX1_ID_LAST);
  endfunction

  function automatic logic [2:0] popcount(input logic [LATENCY:1] v);
    logic [2:0] c;
    c = 3'd0;
    for (int k = 1; k <= LATENCY; k++) begin
      c = c + {2'd0, v[k]};
    end
    return c;
  endfunction

  logic [LATENCY:1]  stage_v_r;
  logic [LATENCY:1]  stage_v_nx_s;
  logic [ADDR_W-1:0] stage_addr_r    [1:LATENCY];
  logic [ADDR_W-1:0] stage_addr_nx_s [1:LATENCY];
  logic [DATA_W-1:0] stage_data_r    [1:LATENCY];
  logic [DATA_W-1:0] stage_data_nx_s [1:LATENCY];
  logic [2:0]        occupancy_r;
  logic              err_illegal_r;
  logic              advance_s;
  logic              accept_s;
  logic              load_s;
  logic              illegal_s;

  assign alu_instr_id = issue_instr_id;
  assign alu_ra       = issue_ra;
  assign alu_rb       = issue_rb;
  assign alu_rc       = issue_rc;
  assign alu_imme7    = issue_imme7;
  assign alu_imme10   = issue_imme10;
  assign alu_imme16   = issue_imme16;
  assign alu_imme18   = issue_imme18;

  // Global stall: the whole pipe freezes while the writeback slot is refused.
  assign advance_s   = ~(stage_v_r[LATENCY] & ~wb_ready);
  assign issue_ready = advance_s & ~flush;
  assign accept_s    = issue_valid & issue_ready;
  assign load_s      = accept_s & is_fx1(issue_instr_id);
  assign illegal_s   = accept_s & ~is_fx1(issue_instr_id);

  assign wb_valid    = stage_v_r[LATENCY] & ~flush;
  assign wb_rt_addr  = stage_addr_r[LATENCY];
  assign wb_data     = stage_data_r[LATENCY];
  assign occupancy   = occupancy_r;
  assign err_illegal = err_illegal_r;

  // Stage 1 sits in the most-significant slice of the forwarding buses.
  for (genvar g = 0; g < LATENCY; g++) begin : g_fwd
    assign fwd_valid[g]                                 = stage_v_r[g+1] & ~flush;
    assign fwd_rt_addr[(LATENCY-1-g)*ADDR_W +: ADDR_W]  = stage_addr_r[g+1];
    assign fwd_data[(LATENCY-1-g)*DATA_W +: DATA_W]     = stage_data_r[g+1];
  end

  // Next pipeline contents: flush clears valids, advance shifts, otherwise hold.
  always_comb begin
    stage_v_nx_s    = stage_v_r;
    stage_addr_nx_s = stage_addr_r;
    stage_data_nx_s = stage_data_r;
    if (flush) begin
      stage_v_nx_s = '0;
    end else if (advance_s) begin
      for (int k = 2; k <= LATENCY; k++) begin
        stage_v_nx_s[k]    = stage_v_r[k-1];
        stage_addr_nx_s[k] = stage_addr_r[k-1];
        stage_data_nx_s[k] = stage_data_r[k-1];
      end
      stage_v_nx_s[1] = load_s;
      if (load_s) begin
        stage_addr_nx_s[1] = issue_rt_addr;
        stage_data_nx_s[1] = alu_result;
      end else begin
        stage_addr_nx_s[1] = stage_addr_r[1];
        stage_data_nx_s[1] = stage_data_r[1];
      end
    end else begin
      stage_v_nx_s = stage_v_r;
    end
  end

  // Pipeline, occupancy and illegal-opcode pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_v_r     <= '0;
      occupancy_r   <= 3'd0;
      err_illegal_r <= 1'b0;
      for (int k = 1; k <= LATENCY; k++) begin
        stage_addr_r[k] <= '0;
        stage_data_r[k] <= '0;
      end
    end else begin
      stage_v_r     <= stage_v_nx_s;
      occupancy_r   <= popcount(stage_v_nx_s);
      err_illegal_r <= illegal_s;
      for (int k = 1; k <= LATENCY; k++) begin
        stage_addr_r[k] <= stage_addr_nx_s[k];
        stage_data_r[k] <= stage_data_nx_s[k];
      end
    end
  end

endmodule

// File: tb/tb_fx1_issue_ctrl.sv
// Directed, table-driven bench for fx1_issue_ctrl (LATENCY=2) with a small
// behavioural model of the external FX1 ALU for the opcodes exercised.
module tb_fx1_issue_ctrl;

  localparam int L  = 2;
  localparam int DW = 128;
  localparam int AW = 7;
  localparam int IW = 7;

  localparam logic [6:0] ID_A   = 7'd1;
  localparam logic [6:0] ID_AI  = 7'd6;
  localparam logic [6:0] ID_IL  = 7'd22;
  localparam logic [6:0] ID_ILA = 7'd23;
  localparam logic [6:0] ID_BAD = 7'd100;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic            issue_ready;
  logic [IW-1:0]   issue_instr_id;
  logic [AW-1:0]   issue_rt_addr;
  logic [DW-1:0]   issue_ra, issue_rb, issue_rc;
  logic [7:0]      issue_imme7;
  logic [9:0]      issue_imme10;
  logic [15:0]     issue_imme16;
  logic [17:0]     issue_imme18;
  logic [IW-1:0]   alu_instr_id;
  logic [DW-1:0]   alu_ra, alu_rb, alu_rc;
  logic [7:0]      alu_imme7;
  logic [9:0]      alu_imme10;
  logic [15:0]     alu_imme16;
  logic [17:0]     alu_imme18;
  logic [DW-1:0]   alu_result;
  logic            flush;
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rt_addr;
  logic [DW-1:0]   wb_data;
  logic [L-1:0]    fwd_valid;
  logic [L*AW-1:0] fwd_rt_addr;
  logic [L*DW-1:0] fwd_data;
  logic [2:0]      occupancy;
  logic            err_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fx1_issue_ctrl #(.LATENCY(L), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr_id(issue_instr_id), .issue_rt_addr(issue_rt_addr),
    .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_rc(issue_rc),
    .issue_imme7(issue_imme7), .issue_imme10(issue_imme10),
    .issue_imme16(issue_imme16), .issue_imme18(issue_imme18),
    .alu_instr_id(alu_instr_id), .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_rc(alu_rc),
    .alu_imme7(alu_imme7), .alu_imme10(alu_imme10),
    .alu_imme16(alu_imme16), .alu_imme18(alu_imme18),
    .alu_result(alu_result), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rt_addr(wb_rt_addr), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_rt_addr(fwd_rt_addr), .fwd_data(fwd_data),
    .occupancy(occupancy), .err_illegal(err_illegal)
  );

  // External ALU model (per 32-bit word); unmodelled opcodes return ra ^ rb.
  always_comb begin
    alu_result = '0;
    for (int w = 0; w < 4; w++) begin
      case (alu_instr_id)
        ID_A:    alu_result[32*w +: 32] = alu_ra[32*w +: 32] + alu_rb[32*w +: 32];
        ID_AI:   alu_result[32*w +: 32] = alu_ra[32*w +: 32] + {{22{alu_imme10[9]}}, alu_imme10};
        ID_IL:   alu_result[32*w +: 32] = {{16{alu_imme16[15]}}, alu_imme16};
        ID_ILA:  alu_result[32*w +: 32] = {14'd0, alu_imme18};
        default: alu_result[32*w +: 32] = alu_ra[32*w +: 32] ^ alu_rb[32*w +: 32];
      endcase
    end
  end

  typedef struct {
    logic        iv;
    logic [6:0]  id;
    logic [6:0]  rt;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [9:0]  i10;
    logic [15:0] i16;
    logic [17:0] i18;
    logic        e_ir;
    logic        e_wbv;
    logic [6:0]  e_wba;
    logic [31:0] e_wbd;
    logic [1:0]  e_fwv;
    logic [6:0]  e_f1a;
    logic [31:0] e_f1d;
    logic [2:0]  e_occ;
    logic        e_err;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    issue_valid    = 1'b0;
    issue_instr_id = '0;
    issue_rt_addr  = '0;
    issue_ra       = '0;
    issue_rb       = '0;
    issue_rc       = '0;
    issue_imme7    = 8'd0;
    issue_imme10   = 10'd0;
    issue_imme16   = 16'd0;
    issue_imme18   = 18'd0;
  endtask

  task automatic set_issue(input logic [6:0] id, input logic [6:0] rt, input logic [31:0] ra,
                           input logic [31:0] rb, input logic [9:0] i10, input logic [15:0] i16,
                           input logic [17:0] i18);
    set_idle();
    issue_valid    = 1'b1;
    issue_instr_id = id;
    issue_rt_addr  = rt;
    issue_ra       = {4{ra}};
    issue_rb       = {4{rb}};
    issue_imme10   = i10;
    issue_imme16   = i16;
    issue_imme18   = i18;
  endtask

  // Called just after a negedge with inputs applied; checks this cycle, returns at next negedge.
  task automatic check_cycle(input string tag, input logic e_ir, input logic e_wbv,
                             input logic [6:0] e_wba, input logic [31:0] e_wbd,
                             input logic [1:0] e_fwv, input logic [6:0] e_f1a,
                             input logic [31:0] e_f1d, input logic [2:0] e_occ, input logic e_err);
    #1;
    chk({tag, ".issue_ready"}, issue_ready, e_ir);
    chk({tag, ".wb_valid"}, wb_valid, e_wbv);
    if (e_wbv) begin
      chk({tag, ".wb_rt_addr"}, wb_rt_addr, e_wba);
      chk({tag, ".wb_data"}, wb_data, {4{e_wbd}});
    end
    chk({tag, ".fwd_valid"}, fwd_valid, e_fwv);
    if (e_fwv[0]) begin
      chk({tag, ".fwd1_addr"}, fwd_rt_addr[L*AW-1 -: AW], e_f1a);
      chk({tag, ".fwd1_data"}, fwd_data[L*DW-1 -: DW], {4{e_f1d}});
    end
    chk({tag, ".occupancy"}, occupancy, e_occ);
    chk({tag, ".err_illegal"}, err_illegal, e_err);
    @(negedge clk);
  endtask

  initial begin
    //           iv id      rt  ra     rb  i10     i16      i18        ir wbv wba wbd          fwv    f1a f1d          occ err
    vecs[0]  = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[1]  = '{1, ID_A,   5,  1,     2,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[2]  = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b01, 5,  32'h3,       1,  0};
    vecs[3]  = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 1,  5,  32'h3,       2'b10, 0,  0,           1,  0};
    vecs[4]  = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[5]  = '{1, ID_IL,  1,  0,     0,  0,      16'h7,   0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[6]  = '{1, ID_ILA, 2,  0,     0,  0,      0,       18'h3FFFF, 1, 0,  0,  0,           2'b01, 1,  32'h7,       1,  0};
    vecs[7]  = '{1, ID_AI,  3,  32'h10, 0, 10'h3FF, 0,      0,         1, 1,  1,  32'h7,       2'b11, 2,  32'h3FFFF,   2,  0};
    vecs[8]  = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 1,  2,  32'h3FFFF,   2'b11, 3,  32'hF,       2,  0};
    vecs[9]  = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 1,  3,  32'hF,       2'b10, 0,  0,           1,  0};
    vecs[10] = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[11] = '{1, ID_BAD, 9,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[12] = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  1};
    vecs[13] = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[14] = '{1, 7'd0,   9,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[15] = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  1};
    vecs[16] = '{1, 7'd41,  4,  5,     6,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};
    vecs[17] = '{1, 7'd42,  8,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b01, 4,  32'h3,       1,  0};
    vecs[18] = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 1,  4,  32'h3,       2'b10, 0,  0,           1,  1};
    vecs[19] = '{0, 7'd0,   0,  0,     0,  0,      0,       0,         1, 0,  0,  0,           2'b00, 0,  0,           0,  0};

    reset    = 1'b1;
    flush    = 1'b0;
    wb_ready = 1'b1;
    set_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].iv) begin
        set_issue(vecs[i].id, vecs[i].rt, vecs[i].ra, vecs[i].rb, vecs[i].i10, vecs[i].i16, vecs[i].i18);
      end else begin
        set_idle();
      end
      check_cycle($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_wbv, vecs[i].e_wba, vecs[i].e_wbd,
                  vecs[i].e_fwv, vecs[i].e_f1a, vecs[i].e_f1d, vecs[i].e_occ, vecs[i].e_err);
    end

    // Full pipe stalled for three cycles, then drained in order.
    set_issue(ID_IL, 7'd11, 0, 0, 0, 16'h11, 0);
    check_cycle("stall_c1", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_issue(ID_IL, 7'd12, 0, 0, 0, 16'h12, 0);
    check_cycle("stall_c2", 1, 0, 0, 0, 2'b01, 7'd11, 32'h11, 1, 0);
    set_issue(ID_IL, 7'd13, 0, 0, 0, 16'h13, 0);
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_cycle($sformatf("stall_hold%0d", c), 0, 1, 7'd11, 32'h11, 2'b11, 7'd12, 32'h12, 2, 0);
    end
    wb_ready = 1'b1;
    check_cycle("stall_rel", 1, 1, 7'd11, 32'h11, 2'b11, 7'd12, 32'h12, 2, 0);
    set_idle();
    check_cycle("drain_12", 1, 1, 7'd12, 32'h12, 2'b11, 7'd13, 32'h13, 2, 0);
    check_cycle("drain_13", 1, 1, 7'd13, 32'h13, 2'b10, 0, 0, 1, 0);
    check_cycle("drain_end", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    // Flush with two in flight and a concurrent issue.
    set_issue(ID_IL, 7'd21, 0, 0, 0, 16'h21, 0);
    check_cycle("fl_c1", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_issue(ID_IL, 7'd22, 0, 0, 0, 16'h22, 0);
    check_cycle("fl_c2", 1, 0, 0, 0, 2'b01, 7'd21, 32'h21, 1, 0);
    set_issue(ID_IL, 7'd23, 0, 0, 0, 16'h23, 0);
    flush = 1'b1;
    check_cycle("fl_c3", 0, 0, 0, 0, 2'b00, 0, 0, 2, 0);
    flush = 1'b0;
    set_idle();
    check_cycle("fl_c4", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    check_cycle("fl_c5", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    check_cycle("fl_c6", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    // Reset while two results are stalled at writeback, with flush and issue also asserted.
    set_issue(ID_IL, 7'd31, 0, 0, 0, 16'h31, 0);
    check_cycle("rs_c1", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    set_issue(ID_IL, 7'd32, 0, 0, 0, 16'h32, 0);
    wb_ready = 1'b0;
    check_cycle("rs_c2", 1, 0, 0, 0, 2'b01, 7'd31, 32'h31, 1, 0);
    set_idle();
    check_cycle("rs_c3", 0, 1, 7'd31, 32'h31, 2'b11, 7'd32, 32'h32, 2, 0);
    reset = 1'b1;
    flush = 1'b1;
    set_issue(ID_BAD, 7'd9, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    set_idle();
    #1;
    chk("rs_after.wb_rt_addr", wb_rt_addr, 7'd0);
    chk("rs_after.wb_data", wb_data, 128'd0);
    check_cycle("rs_after", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    wb_ready = 1'b1;
    check_cycle("rs_after2", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
